// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: control bundle width, bit positions
// and the default kill mask used by the EX->MEM squash stage.
package pipe_ctrl_pkg;

   localparam int CTRL_W        = 6;

   localparam int CTRL_BRANCH   = 0;
   localparam int CTRL_JUMP     = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_MEMTOREG = 4;
   localparam int CTRL_REGWRITE = 5;

   localparam logic [CTRL_W-1:0] KILL_ALL = {CTRL_W{1'b1}};

   localparam int SQ_CNT_W      = 4;

endpackage

// File: rtl/squash_window_ctr.sv
// Reload/decrement counter defining the squash window that follows a
// branch misprediction; active covers the asserting cycle plus the tail.
module squash_window_ctr
   import pipe_ctrl_pkg::*;
#(
   parameter int SQUASH_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                en,
   output logic                active,
   output logic [SQ_CNT_W-1:0] cnt
);

   localparam logic [SQ_CNT_W-1:0] RELOAD = SQ_CNT_W'(SQUASH_CYCLES - 1);

   logic [SQ_CNT_W-1:0] r_cnt_p1;

   generate
      if (SQUASH_CYCLES < 1 || SQUASH_CYCLES > 15) begin : g_bad_cycles
         $error("SQUASH_CYCLES must be in 1..15");
      end
   endgenerate

   // Reload wins over hold so a misprediction during a stall restarts the window.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt_p1 <= '0;
      end else if (load) begin
         r_cnt_p1 <= RELOAD;
      end else if (en && r_cnt_p1 != '0) begin
         r_cnt_p1 <= r_cnt_p1 - 1'b1;
      end
   end

   assign active = load | (r_cnt_p1 != '0);
   assign cnt    = r_cnt_p1;

endmodule

// File: rtl/ex_mem_squash_stage.sv
// EX->MEM pipeline register that kills control bits for a configurable
// window after a misprediction, honours stall and counts squashed work.
module ex_mem_squash_stage
   import pipe_ctrl_pkg::*;
#(
   parameter int                CTRL_W        = pipe_ctrl_pkg::CTRL_W,
   parameter int                DATA_W        = 32,
   parameter int                SQUASH_CYCLES = 1,
   parameter logic [CTRL_W-1:0] KILL_MASK     = {CTRL_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              wrong_prediction,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              squash_active,
   output logic [15:0]       squashed_total
);

   logic                w_kill;
   logic                w_load;
   logic [SQ_CNT_W-1:0] w_cnt;
   logic [CTRL_W-1:0]   w_ctrl_masked;

   logic [CTRL_W-1:0]   r_ctrl_p1;
   logic [DATA_W-1:0]   r_data_p1;
   logic                r_vld_p1;
   logic [15:0]         r_squashed_total;

   squash_window_ctr #(
      .SQUASH_CYCLES (SQUASH_CYCLES)
   ) u_window (
      .clk    (clk),
      .reset  (reset),
      .load   (wrong_prediction),
      .en     (!stall),
      .active (w_kill),
      .cnt    (w_cnt)
   );

   // A misprediction overrides stall so a held wrong-path entry gets killed.
   assign w_load        = wrong_prediction | ~stall;
   assign w_ctrl_masked = ctrl_in & ~KILL_MASK;

   // ---- EX -> MEM register boundary ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl_p1        <= '0;
         r_data_p1        <= '0;
         r_vld_p1         <= 1'b0;
         r_squashed_total <= '0;
      end else if (w_load) begin
         r_data_p1 <= data_in;
         if (w_kill) begin
            r_ctrl_p1 <= w_ctrl_masked;
            r_vld_p1  <= 1'b0;
            if (valid_in && r_squashed_total != 16'hFFFF) begin
               r_squashed_total <= r_squashed_total + 16'd1;
            end
         end else begin
            r_ctrl_p1 <= valid_in ? ctrl_in : w_ctrl_masked;
            r_vld_p1  <= valid_in;
         end
      end
   end

   assign ctrl_out       = r_ctrl_p1;
   assign data_out       = r_data_p1;
   assign valid_out      = r_vld_p1;
   assign squash_active  = w_kill;
   assign squashed_total = r_squashed_total;

endmodule

// File: tb/tb_ex_mem_squash_stage.sv
// Scoreboard bench for ex_mem_squash_stage: three parameterisations share one
// stimulus stream and are checked against an in-bench reference model.
module tb_ex_mem_squash_stage;

   typedef struct packed {
      logic [5:0]  c;
      logic [31:0] d;
      logic        v;
      logic [15:0] t;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  ctrl_in;
   logic [31:0] data_in;
   logic        valid_in;
   logic        stall;
   logic        wrong_prediction;

   logic [5:0]  o_ctrl [3];
   logic [31:0] o_data [3];
   logic        o_vld  [3];
   logic        o_act  [3];
   logic [15:0] o_tot  [3];

   int          n_assert = 0;
   int          n_fail   = 0;

   // model state per instance
   int          mN    [3] = '{1, 3, 1};
   logic [5:0]  mMask [3] = '{6'h3F, 6'h3F, 6'b111100};
   logic [5:0]  m_ctrl[3];
   logic [31:0] m_data[3];
   logic        m_vld [3];
   logic [3:0]  m_cnt [3];
   logic [15:0] m_tot [3];

   exp_t        q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   ex_mem_squash_stage #(.CTRL_W(6), .DATA_W(32), .SQUASH_CYCLES(1), .KILL_MASK(6'h3F)) dut1 (
      .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .data_in(data_in), .valid_in(valid_in),
      .stall(stall), .wrong_prediction(wrong_prediction), .ctrl_out(o_ctrl[0]), .data_out(o_data[0]),
      .valid_out(o_vld[0]), .squash_active(o_act[0]), .squashed_total(o_tot[0]));

   ex_mem_squash_stage #(.CTRL_W(6), .DATA_W(32), .SQUASH_CYCLES(3), .KILL_MASK(6'h3F)) dut3 (
      .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .data_in(data_in), .valid_in(valid_in),
      .stall(stall), .wrong_prediction(wrong_prediction), .ctrl_out(o_ctrl[1]), .data_out(o_data[1]),
      .valid_out(o_vld[1]), .squash_active(o_act[1]), .squashed_total(o_tot[1]));

   ex_mem_squash_stage #(.CTRL_W(6), .DATA_W(32), .SQUASH_CYCLES(1), .KILL_MASK(6'b111100)) dutm (
      .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .data_in(data_in), .valid_in(valid_in),
      .stall(stall), .wrong_prediction(wrong_prediction), .ctrl_out(o_ctrl[2]), .data_out(o_data[2]),
      .valid_out(o_vld[2]), .squash_active(o_act[2]), .squashed_total(o_tot[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model for instance k and return the expected post-edge outputs.
   function automatic exp_t model_step(input int k);
      exp_t e;
      logic kill;
      if (reset) begin
         m_ctrl[k] = '0; m_data[k] = '0; m_vld[k] = 1'b0; m_cnt[k] = '0; m_tot[k] = '0;
      end else begin
         kill = wrong_prediction | (m_cnt[k] != 4'd0);
         if (wrong_prediction || !stall) begin
            m_data[k] = data_in;
            if (kill) begin
               m_ctrl[k] = ctrl_in & ~mMask[k];
               m_vld[k]  = 1'b0;
               if (valid_in && m_tot[k] != 16'hFFFF) m_tot[k] = m_tot[k] + 16'd1;
            end else begin
               m_ctrl[k] = valid_in ? ctrl_in : (ctrl_in & ~mMask[k]);
               m_vld[k]  = valid_in;
            end
         end
         if (wrong_prediction) m_cnt[k] = 4'(mN[k] - 1);
         else if (!stall && m_cnt[k] != 4'd0) m_cnt[k] = m_cnt[k] - 4'd1;
      end
      e.c = m_ctrl[k]; e.d = m_data[k]; e.v = m_vld[k]; e.t = m_tot[k];
      return e;
   endfunction

   task automatic cmp_out(input int k, input exp_t e);
      chk($sformatf("ctrl_out[%0d]", k), {26'd0, o_ctrl[k]}, {26'd0, e.c});
      chk($sformatf("data_out[%0d]", k), o_data[k], e.d);
      chk($sformatf("valid_out[%0d]", k), {31'd0, o_vld[k]}, {31'd0, e.v});
      chk($sformatf("squashed_total[%0d]", k), {16'd0, o_tot[k]}, {16'd0, e.t});
   endtask

   task automatic step(input logic rst, input logic [5:0] c, input logic [31:0] d,
                       input logic vin, input logic stl, input logic wp);
      exp_t e;
      @(negedge clk);
      reset = rst; ctrl_in = c; data_in = d; valid_in = vin; stall = stl; wrong_prediction = wp;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("squash_active[%0d]", k), {31'd0, o_act[k]},
             {31'd0, (wp | (m_cnt[k] != 4'd0))});
      end
      q0.push_back(model_step(0));
      q1.push_back(model_step(1));
      q2.push_back(model_step(2));
      @(posedge clk);
      #1;
      e = q0.pop_front(); cmp_out(0, e);
      e = q1.pop_front(); cmp_out(1, e);
      e = q2.pop_front(); cmp_out(2, e);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_ctrl[k] = '0; m_data[k] = '0; m_vld[k] = 1'b0; m_cnt[k] = '0; m_tot[k] = '0;
      end
      reset = 1'b1; ctrl_in = 6'h3F; data_in = 32'hDEADBEEF; valid_in = 1'b1;
      stall = 1'b0; wrong_prediction = 1'b0;

      // reset held for two cycles, then first normal load
      step(1, 6'h3F, 32'hDEADBEEF, 1, 0, 0);
      step(1, 6'h3F, 32'hDEADBEEF, 1, 0, 0);
      chk("reset_ctrl", {26'd0, o_ctrl[0]}, 32'd0);
      chk("reset_valid", {31'd0, o_vld[0]}, 32'd0);
      step(0, 6'h3F, 32'hDEADBEEF, 1, 0, 0);
      chk("first_load_ctrl", {26'd0, o_ctrl[0]}, 32'h3F);
      chk("first_load_valid", {31'd0, o_vld[0]}, 32'd1);

      // single squash
      step(0, 6'h24, 32'h0000_1234, 1, 0, 1);
      chk("single_sq_ctrl", {26'd0, o_ctrl[0]}, 32'd0);
      chk("single_sq_data", o_data[0], 32'h0000_1234);
      chk("single_sq_total", {16'd0, o_tot[0]}, 32'd1);
      step(0, 6'h24, 32'h0000_1235, 1, 0, 0);
      chk("single_after_ctrl", {26'd0, o_ctrl[0]}, 32'h24);
      step(0, 6'h21, 32'h0000_1236, 1, 0, 0);
      step(0, 6'h22, 32'h0000_1237, 1, 0, 0);
      step(0, 6'h10, 32'h0000_1238, 0, 0, 0);

      // multi-cycle squash from clean totals
      step(1, 6'h00, 32'h0, 0, 0, 0);
      step(0, 6'h3F, 32'hA000_0000, 1, 0, 1);
      step(0, 6'h3F, 32'hA000_0001, 1, 0, 0);
      step(0, 6'h3F, 32'hA000_0002, 1, 0, 0);
      chk("multi_total", {16'd0, o_tot[1]}, 32'd3);
      step(0, 6'h3F, 32'hA000_0003, 1, 0, 0);
      chk("multi_after_valid", {31'd0, o_vld[1]}, 32'd1);

      // stall inside the window, then misprediction during stall
      step(0, 6'h30, 32'hB000_0000, 1, 0, 1);
      step(0, 6'h31, 32'hB000_0001, 1, 1, 0);
      step(0, 6'h32, 32'hB000_0002, 1, 1, 0);
      step(0, 6'h33, 32'hB000_0003, 1, 0, 0);
      step(0, 6'h34, 32'hB000_0004, 1, 0, 0);
      step(0, 6'h35, 32'hB000_0005, 1, 0, 0);
      step(0, 6'h36, 32'hB000_0006, 1, 0, 0);
      step(0, 6'h37, 32'hB000_0007, 1, 1, 0);
      step(0, 6'h38, 32'hB000_0008, 1, 1, 1);
      step(0, 6'h39, 32'hB000_0009, 1, 0, 0);
      step(0, 6'h3A, 32'hB000_000A, 1, 0, 0);
      step(0, 6'h3B, 32'hB000_000B, 1, 0, 0);

      // partial kill mask
      step(0, 6'b000011, 32'hC000_0000, 1, 0, 1);
      chk("mask_ctrl", {26'd0, o_ctrl[2]}, 32'h03);
      chk("mask_valid", {31'd0, o_vld[2]}, 32'd0);
      step(0, 6'h0F, 32'hC000_0001, 1, 0, 0);
      step(0, 6'h0F, 32'hC000_0002, 0, 0, 0);
      step(0, 6'h0F, 32'hC000_0003, 1, 0, 0);

      // window reload at slot 2
      step(1, 6'h00, 32'h0, 0, 0, 0);
      step(0, 6'h2A, 32'hD000_0000, 1, 0, 1);
      step(0, 6'h2A, 32'hD000_0001, 1, 0, 0);
      step(0, 6'h2A, 32'hD000_0002, 1, 0, 1);
      step(0, 6'h2A, 32'hD000_0003, 1, 0, 0);
      step(0, 6'h2A, 32'hD000_0004, 1, 0, 0);
      chk("reload_total", {16'd0, o_tot[1]}, 32'd5);
      step(0, 6'h2A, 32'hD000_0005, 1, 0, 0);
      chk("reload_after_valid", {31'd0, o_vld[1]}, 32'd1);

      // saturation of the squash counter
      for (int i = 0; i < 65540; i++) begin
         step(0, 6'h3F, 32'(i), 1, 0, 1);
      end
      chk("sat_total_a", {16'd0, o_tot[0]}, 32'hFFFF);
      for (int i = 0; i < 3; i++) begin
         step(0, 6'h3F, 32'hE000_0000, 1, 0, 1);
         step(0, 6'h3F, 32'hE000_0001, 1, 0, 0);
      end
      chk("sat_total_b", {16'd0, o_tot[1]}, 32'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_mem_squash_stage.md
# ex_mem_squash_stage

Parametrised EX→MEM pipeline register for control and data.
- Squashes the control bundle on a branch misprediction, optionally for several consecutive cycles.
- Honours a pipeline stall and counts squashed instructions.
- Sits between the EX-stage control/ALU outputs and the MEM stage. It replaces the purely combinational control-zeroing mux with a registered stage that owns its own flush window.

## Interface
Parameters:
- CTRL_W, 6, width of the control bundle; bit order is branch, jump, memRead, memWrite, memToReg, regWrite (bit 0..5).
- DATA_W, 32, width of the data payload (ALU result, store data, destination register packed by the caller).
- SQUASH_CYCLES, 1, number of consecutive stage loads squashed per misprediction, counting the asserting cycle; legal range 1..15.
- KILL_MASK, {CTRL_W{1'b1}}, control bits forced to 0 on squash; bits with mask 0 pass through unchanged.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_in  in  CTRL_W  EX-stage control bundle.
- data_in  in  DATA_W  EX-stage data payload.
- valid_in  in  1  EX stage holds a real instruction.
- stall  in  1  MEM stage not ready; hold the register.
- wrong_prediction  in  1  misprediction resolved this cycle.
- ctrl_out  out  CTRL_W  registered control to MEM.
- data_out  out  DATA_W  registered payload to MEM.
- valid_out  out  1  registered valid.
- squash_active  out  1  a squash window is open (combinational: wrong_prediction | cnt≠0).
- squashed_total  out  16  saturating count of squashed valid instructions.

## Operation
- Reset: ctrl_out=0, data_out=0, valid_out=0, cnt=0, squashed_total=0.
- kill = wrong_prediction | (cnt≠0).
- Priority of the stage register: reset > wrong_prediction > stall > normal load.
  - wrong_prediction=1 loads even while stall=1, so a held wrong-path instruction is killed.
  - stall=1 with wrong_prediction=0 holds ctrl_out, data_out, valid_out and cnt, even while cnt≠0.
  - Killed load: ctrl_out ← ctrl_in & ~KILL_MASK, data_out ← data_in, valid_out ← 0.
  - Normal load: ctrl_out ← valid_in ? ctrl_in : ctrl_in & ~KILL_MASK; data_out ← data_in; valid_out ← valid_in.
- Squash counter, width 4:
  - wrong_prediction=1 loads cnt ← SQUASH_CYCLES−1. Reassertion mid-window reloads it; windows do not accumulate.
  - Otherwise, when not stalled and cnt≠0, cnt decrements.
  - SQUASH_CYCLES=1 never leaves cnt nonzero. This is exactly the single-cycle zeroing behaviour, but registered.
- squashed_total increments by 1 on every killed load with valid_in=1. It saturates at 0xFFFF and never wraps.

## Timing
- Latency: 1 cycle, ctrl_in/data_in → ctrl_out/data_out.
- The misprediction cycle's load is killed at the next edge.
- With SQUASH_CYCLES=N and no stall, the N loads at edges t+1..t+N are killed; load t+N+1 is normal.
- Stall cycles inside a window do not consume window slots, except a cycle where wrong_prediction is also asserted.
- squash_active is high from the wrong_prediction cycle through the last killed cycle.
- Reset asserted mid-window clears cnt. The first load after reset deasserts is normal unless wrong_prediction=1.
- No combinational path from inputs to ctrl_out/data_out/valid_out.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - CTRL_W default;
  - bit-index constants CTRL_BRANCH=0, CTRL_JUMP=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_MEMTOREG=4, CTRL_REGWRITE=5;
  - KILL_ALL mask constant.
- One sub-module, squash_window_ctr. It holds the reload/decrement counter, with inputs load/en and outputs active/cnt.
- The stage register and the statistics counter stay in the top module.

## Test plan
- Reset: drive ctrl_in=6'h3F, data_in=32'hDEADBEEF with reset=1 for 2 cycles. Required: all outputs 0. On the first edge after release: ctrl_out=6'h3F, valid_out=1.
- Single squash (N=1): wrong_prediction=1 for one cycle with ctrl_in=6'h24, valid_in=1.
  - Required next edge: ctrl_out=0, valid_out=0, data_out=data_in, squashed_total=1.
  - Required on the following edge: a normal load.
- Multi-cycle squash (N=3): one-cycle wrong_prediction with valid_in=1 throughout. Required: 3 consecutive killed loads, then normal; squashed_total=3.
- Stall interaction (N=3):
  - Stall for 2 cycles after the wrong_prediction cycle. Required: cnt holds at 2 and ctrl_out holds 0 during the stall; 3 killed loads total.
  - Also wrong_prediction during stall. Required: the held entry is killed.
- Partial mask: KILL_MASK=6'b111100 with ctrl_in=6'b000011 on squash. Required: ctrl_out=6'b000011, valid_out=0.
- Reload and saturation:
  - Wrong_prediction again at window slot 2 (N=3). Required: window restarts, 5 killed loads total.
  - Preload squashed_total=0xFFFE, then 3 squashes. Required: stays 0xFFFF.
